// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the N-way signal controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Lamp pattern shown by the way currently being served.
  function automatic logic [2:0] active_lamp(input phase_t ph);
    case (ph)
      GREEN:   return LIGHT_GREEN;
      YELLOW:  return LIGHT_YELLOW;
      default: return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase timer: clears on request, advances only on timebase ticks.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_tick,
  output logic [TIMER_W-1:0] o_count
);

  logic [TIMER_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_tick && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_light_controller_nway.sv
// Demand-actuated N-way round-robin signal controller.
// Optional emergency pre-emption is enabled by defining EMERGENCY_PREEMPT_EN.
module traffic_light_controller_nway
  import traffic_pkg::*;
#(
  parameter int  NUM_WAYS  = 4,
  parameter int  TIMER_W   = 8,
  parameter int  MIN_GREEN = 4,
  parameter int  MAX_GREEN = 8,
  parameter int  YELLOW_T  = 2,
  parameter int  ALL_RED_T = 1,
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_WAYS-1:0]   demand,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [NUM_WAYS-1:0]   emerg_req,
`endif
  output logic [3*NUM_WAYS-1:0] lights,
  output logic [WAY_W-1:0]      active_way,
  output logic [1:0]            phase
);

  localparam logic [TIMER_W-1:0] AR_LAST   = TIMER_W'(ALL_RED_T - 1);
  localparam logic [TIMER_W-1:0] MING_LAST = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAXG_LAST = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_T - 1);

  phase_t              r_phase, w_phase_nxt;
  logic [WAY_W-1:0]    r_active_way, w_way_nxt, w_rr_way;
  logic [NUM_WAYS-1:0] r_pend, w_pend_nxt, w_green_clr;
  logic [TIMER_W-1:0]  w_timer;
  logic                w_rr_found, w_others_pend;

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_phase_nxt != r_phase),
    .i_tick  (tick),
    .o_count (w_timer)
  );

  // Round-robin: first pending way after the one last served, wrapping to itself last.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_way   = r_active_way;
    for (int k = 1; k <= NUM_WAYS; k++) begin
      logic [WAY_W-1:0] idx;
      idx = WAY_W'((int'(r_active_way) + k) % NUM_WAYS);
      if (!w_rr_found && r_pend[idx]) begin
        w_rr_found = 1'b1;
        w_rr_way   = idx;
      end
    end
  end

  assign w_others_pend = |(r_pend & ~(NUM_WAYS'(1) << r_active_way));

`ifdef EMERGENCY_PREEMPT_EN
  logic             w_emerg_any;
  logic [WAY_W-1:0] w_emerg_way;

  always_comb begin
    w_emerg_any = 1'b0;
    w_emerg_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!w_emerg_any && emerg_req[i]) begin
        w_emerg_any = 1'b1;
        w_emerg_way = WAY_W'(i);
      end
    end
  end
`endif

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    w_phase_nxt = r_phase;
    w_way_nxt   = r_active_way;
    case (r_phase)
      ALL_RED: begin
        if (tick && (w_timer >= AR_LAST)) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (w_emerg_any) begin
            w_phase_nxt = GREEN;
            w_way_nxt   = w_emerg_way;
          end else
`endif
          if (w_rr_found) begin
            w_phase_nxt = GREEN;
            w_way_nxt   = w_rr_way;
          end
        end
      end
      GREEN: begin
        if (tick) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (w_emerg_any && (w_emerg_way != r_active_way)) begin
            w_phase_nxt = YELLOW;
          end else if (w_emerg_any) begin
            w_phase_nxt = GREEN;
          end else
`endif
          if ((w_timer >= MAXG_LAST) ||
              ((w_timer >= MING_LAST) && !demand[r_active_way] && w_others_pend)) begin
            w_phase_nxt = YELLOW;
          end
        end
      end
      YELLOW: begin
        if (tick && (w_timer == YEL_LAST)) w_phase_nxt = ALL_RED;
      end
      default: w_phase_nxt = ALL_RED;
    endcase
  end

  // Pending is cleared on green entry, but a demand seen the same cycle re-arms it.
  assign w_green_clr = ((r_phase != GREEN) && (w_phase_nxt == GREEN)) ?
                       (NUM_WAYS'(1) << w_way_nxt) : '0;
  assign w_pend_nxt  = demand | (r_pend & ~w_green_clr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase      <= ALL_RED;
      r_active_way <= WAY_W'(NUM_WAYS - 1);
      r_pend       <= '0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_active_way <= w_way_nxt;
      r_pend       <= w_pend_nxt;
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      lights[3*i +: 3] = (WAY_W'(i) == r_active_way) ? active_lamp(r_phase) : LIGHT_RED;
    end
  end

  assign active_way = r_active_way;
  assign phase      = r_phase;

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// Scoreboard bench for traffic_light_controller_nway at default parameters.
// Define EMERGENCY_PREEMPT_EN to also exercise pre-emption.
module tb_traffic_light_controller_nway;

  localparam logic [1:0] P_AR = 2'd0;
  localparam logic [1:0] P_G  = 2'd1;
  localparam logic [1:0] P_Y  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [3:0]  demand;
  logic [3:0]  emerg_req;
  logic [11:0] lights;
  logic [1:0]  active_way;
  logic [1:0]  phase;

  typedef struct {
    logic [1:0] ph;
    logic [1:0] way;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;

  traffic_light_controller_nway dut (
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req  (emerg_req),
`endif
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .demand     (demand),
    .lights     (lights),
    .active_way (active_way),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_lights(input logic [1:0] ph, input logic [1:0] way);
    logic [11:0] l;
    l = 12'h924;
    case (ph)
      P_G:     l[3*way +: 3] = 3'b001;
      P_Y:     l[3*way +: 3] = 3'b010;
      default: l[3*way +: 3] = 3'b100;
    endcase
    return l;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One clock edge, then queue the state expected after it.
  task automatic cyc(input logic [1:0] ph, input logic [1:0] way, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.ph   = ph;
    e.way  = way;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic cycn(input logic [1:0] ph, input logic [1:0] way, input int n, input string nm);
    repeat (n) cyc(ph, way, nm);
  endtask

  // Same as cycn, but tick alternates 1,0,1,0... across the whole sequence.
  task automatic tcyc(input logic [1:0] ph, input logic [1:0] way, input int n, input string nm);
    repeat (n) begin
      k++;
      tick = k[0];
      cyc(ph, way, nm);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.name, ".phase"},  32'(phase),      32'(e.ph));
        check({e.name, ".way"},    32'(active_way), 32'(e.way));
        check({e.name, ".lights"}, 32'(lights),     32'(exp_lights(e.ph, e.way)));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    tick      = 1'b1;
    demand    = 4'b0000;
    emerg_req = 4'b0000;

    // Reset held three cycles
    cycn(P_AR, 2'd3, 3, "t1_reset");

    // Full demand: 8 green, 2 yellow, 1 all-red per way, order 0,1,2,3,0
    rst    = 1'b1;
    demand = 4'b1111;
    cyc(P_AR, 2'd3, "t2_latch");
    for (int w = 0; w < 4; w++) begin
      cycn(P_G,  2'(w), 8, "t2_green");
      cycn(P_Y,  2'(w), 2, "t2_yellow");
      cycn(P_AR, 2'(w), 1, "t2_allred");
    end
    cycn(P_G, 2'd0, 3, "t2_wrap");
    rst    = 1'b0;
    demand = 4'b0000;
    cyc(P_AR, 2'd3, "t2_rst_mid_green");

    // Single pulse on way 2, then way 0 pending forces gap-out at green cycle 4
    rst    = 1'b1;
    demand = 4'b0100;
    cyc(P_AR, 2'd3, "t3_latch");
    demand = 4'b0000;
    cycn(P_G, 2'd2, 2, "t3_green_alone");
    demand = 4'b0001;
    cyc(P_G, 2'd2, "t3_green_pend0");
    demand = 4'b0000;
    cyc(P_G, 2'd2, "t3_green4");
    cycn(P_Y,  2'd2, 2, "t3_gapout_yellow");
    cyc(P_AR, 2'd2, "t3_allred");
    cycn(P_G,  2'd0, 8, "t3_max_green");
    cycn(P_Y,  2'd0, 2, "t3_yellow");
    cycn(P_AR, 2'd0, 5, "t3_idle");

    // No demand: park in all-red; a pulse on way 1 serves it next
    rst = 1'b0;
    cyc(P_AR, 2'd3, "t4_rst");
    rst = 1'b1;
    cycn(P_AR, 2'd3, 50, "t4_idle");
    demand = 4'b0010;
    cyc(P_AR, 2'd3, "t4_latch");
    demand = 4'b0000;
    cycn(P_G,  2'd1, 8, "t4_green");
    cycn(P_Y,  2'd1, 2, "t4_yellow");
    cyc(P_AR, 2'd1, "t4_allred");

    // Tick every other clock: durations double; reset during green
    rst = 1'b0;
    cyc(P_AR, 2'd3, "t5_rst");
    rst    = 1'b1;
    demand = 4'b0001;
    tcyc(P_AR, 2'd3, 2,  "t5_wait");
    tcyc(P_G,  2'd0, 16, "t5_green");
    tcyc(P_Y,  2'd0, 4,  "t5_yellow4");
    tcyc(P_AR, 2'd0, 2,  "t5_allred");
    tcyc(P_G,  2'd0, 1,  "t5_reselect");
    rst = 1'b0;
    tcyc(P_AR, 2'd3, 1, "t5_rst_in_green");
    tick = 1'b1;

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency on way 3 during way 0 green at timer=1
    rst    = 1'b1;
    demand = 4'b0001;
    cyc(P_AR, 2'd3, "t6_latch");
    cycn(P_G, 2'd0, 2, "t6_green0");
    emerg_req = 4'b1000;
    cycn(P_Y,  2'd0, 2,  "t6_preempt_yellow");
    cyc(P_AR, 2'd0, "t6_allred");
    cycn(P_G,  2'd3, 12, "t6_emerg_hold");
    emerg_req = 4'b0000;
    cycn(P_Y,  2'd3, 2,  "t6_release");
`endif

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
